// File: rtl/ct_f_spsram_ctrl.sv
// Single-port SRAM controller: clears the whole array after reset, then serves
// one read or write per cycle, returning read data through a 2-entry FIFO.
//
// Handshakes: a request transfers on a rising edge where req_vld && req_rdy;
// a response transfers on a rising edge where rsp_vld && rsp_rdy. A valid
// is held with its payload stable until the matching ready is seen high.
module ct_f_spsram_ctrl (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_wr,
    input  logic [10:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        init_done,
    output logic [10:0] sram_a,
    output logic        sram_cen,
    output logic        sram_gwen,
    output logic [31:0] sram_wen,
    output logic [31:0] sram_d,
    input  logic [31:0] sram_q,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        INIT     = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] init_cnt;
    logic        inflight;
    logic [1:0]  fifo_cnt;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] fifo_mem [2];
    logic        push;
    logic        pop;
    logic [2:0]  occupancy;
    logic        accept;
    logic        rd_acc;
    logic        wr_acc;
    logic [31:0] be_mask;

    assign dbg_state = state;

    // State register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) state <= RST_WAIT;
        else           state <= state_nxt;
    end

    // Next state: one wait cycle, 2048 clear cycles, then run until reset
    always_comb begin
        state_nxt = state;
        case (state)
            RST_WAIT: state_nxt = INIT;
            INIT:     if (init_cnt == 11'h7FF) state_nxt = RUN;
            RUN:      state_nxt = RUN;
            default:  state_nxt = RST_WAIT;
        endcase
    end

    // Clear-address counter, advances once per INIT cycle
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)          init_cnt <= '0;
        else if (state == INIT) init_cnt <= init_cnt + 11'd1;
    end

    // Registered init_done, high exactly while in RUN
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) init_done <= 1'b0;
        else           init_done <= (state_nxt == RUN);
    end

    // A pop in the same cycle frees a slot, so streaming reads keep req_rdy high
    assign push      = inflight;
    assign pop       = rsp_vld && rsp_rdy;
    assign occupancy = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign req_rdy   = init_done && (occupancy < 3'd2);
    assign accept    = req_vld && req_rdy;
    assign rd_acc    = accept && !req_wr;
    assign wr_acc    = accept && req_wr && (req_be != 4'b0000);

    // Expand byte enables into the active-low per-bit write mask
    always_comb begin
        be_mask = '1;
        for (int k = 0; k < 4; k++) begin
            be_mask[8*k +: 8] = {8{~req_be[k]}};
        end
    end

    // SRAM port drive: clear pattern in INIT, pass-through request in RUN
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = init_cnt;
        sram_d    = '0;
        case (state)
            INIT: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
            end
            RUN: begin
                sram_a = req_addr;
                sram_d = req_wdata;
                if (wr_acc) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = be_mask;
                end else if (rd_acc) begin
                    sram_cen  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // In-flight flag marks the cycle sram_q carries the accepted read's data
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) inflight <= 1'b0;
        else           inflight <= rd_acc;
    end

    // Response FIFO: 2 entries, 1-bit wrapping pointers, push/pop may coincide
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rsp_vld   = (fifo_cnt != 2'd0);
    assign rsp_rdata = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_ct_f_spsram_ctrl.sv
// Bench for ct_f_spsram_ctrl: behavioural SRAM, reference memory image,
// expected-response queue checked whenever a response is consumed.
module tb_ct_f_spsram_ctrl;

    // Clock and reset
    logic forever_cpuclk = 1'b0;
    logic cpurst_b       = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic        req_wr = 1'b0;
    logic [10:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic [10:0] sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [31:0] sram_wen;
    logic [31:0] sram_d;
    logic [31:0] sram_q = '0;
    logic [1:0]  dbg_state;

    logic [31:0] sram_mem [2048];
    logic [31:0] ref_mem  [2048];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic        rand_phase;
    int          n_cmp = 0;
    int          n_err = 0;

    ct_f_spsram_ctrl dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_be         (req_be),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q),
        .dbg_state      (dbg_state)
    );

    // Behavioural single-port SRAM, read data one cycle after the access
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] be_to_wen(input logic [3:0] be);
        be_to_wen = ~{{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    endtask

    // Scoreboard: compare every consumed response against the queue head
    always @(negedge forever_cpuclk) begin
        if (cpurst_b && rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("rsp_data", rsp_rdata, mon_exp);
            end
        end
    end

    // Driver: present one request, wait for acceptance, check the SRAM port
    task automatic do_req(input logic wr, input logic [10:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int waits);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        waits     = 0;
        @(negedge forever_cpuclk);
        while (!req_rdy && waits < 100) begin
            waits++;
            @(negedge forever_cpuclk);
        end
        if (!req_rdy) begin
            check_eq("req_timeout", 32'(req_rdy), 32'd1);
        end else begin
            check_eq("acc_addr", 32'(sram_a), 32'(addr));
            if (wr) begin
                check_eq("wr_cen", 32'(sram_cen), (be == 4'h0) ? 32'd1 : 32'd0);
                check_eq("wr_gwen", 32'(sram_gwen), (be == 4'h0) ? 32'd1 : 32'd0);
                check_eq("wr_wen", sram_wen, (be == 4'h0) ? 32'hFFFF_FFFF : be_to_wen(be));
                check_eq("wr_d", sram_d, data);
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) ref_mem[addr][8*k +: 8] = data[8*k +: 8];
                end
            end else begin
                check_eq("rd_cen", 32'(sram_cen), 32'd0);
                check_eq("rd_gwen", 32'(sram_gwen), 32'd1);
                check_eq("rd_wen", sram_wen, 32'hFFFF_FFFF);
                exp_q.push_back(ref_mem[addr]);
            end
        end
        @(posedge forever_cpuclk);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
        check_eq({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check_eq({tag, "_init_done"}, 32'(init_done), 32'd0);
        check_eq({tag, "_cen"}, 32'(sram_cen), 32'd1);
        check_eq({tag, "_gwen"}, 32'(sram_gwen), 32'd1);
        check_eq({tag, "_wen"}, sram_wen, 32'hFFFF_FFFF);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // Called at posedge+1 right after reset release; follows the full clear sweep
    task automatic check_init_sweep(input string tag);
        int waited;
        int bad_a;
        int bad_ctl;
        waited  = 0;
        bad_a   = 0;
        bad_ctl = 0;
        @(negedge forever_cpuclk);
        while (sram_cen && waited < 5) begin
            waited++;
            @(negedge forever_cpuclk);
        end
        check_eq({tag, "_start_delay"}, 32'(waited), 32'd1);
        for (int i = 0; i < 2048; i++) begin
            if (sram_a != 11'(i)) bad_a++;
            if (sram_cen || sram_gwen || sram_wen != 32'd0 || sram_d != 32'd0) bad_ctl++;
            if (init_done || req_rdy) bad_ctl++;
            @(negedge forever_cpuclk);
        end
        check_eq({tag, "_addr_seq"}, 32'(bad_a), 32'd0);
        check_eq({tag, "_ctl_seq"}, 32'(bad_ctl), 32'd0);
        check_eq({tag, "_done"}, 32'(init_done), 32'd1);
        check_eq({tag, "_idle_cen"}, 32'(sram_cen), 32'd1);
        check_eq({tag, "_rdy"}, 32'(req_rdy), 32'd1);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd2);
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge forever_cpuclk);
        end
        check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        @(posedge forever_cpuclk);
        #1;
    endtask

    initial begin
        int w;
        int wsum;
        int run;
        int nwait;
        for (int i = 0; i < 2048; i++) sram_mem[i] = $urandom;
        clear_ref();
        rand_phase = 1'b0;

        // Reset values while held, then the first clear sweep
        repeat (2) @(negedge forever_cpuclk);
        check_reset_outputs("rst0");
        @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        check_init_sweep("init0");

        // Top address cleared
        rsp_rdy = 1'b1;
        do_req(1'b0, 11'h7FF, 32'd0, 4'h0, w);
        wait_drain("top");

        // Byte-merge and read latency
        do_req(1'b1, 11'h005, 32'hA1B2C3D4, 4'hF, w);
        do_req(1'b1, 11'h005, 32'hFFFFFFFF, 4'h2, w);
        do_req(1'b0, 11'h005, 32'd0, 4'h0, w);
        @(negedge forever_cpuclk);
        check_eq("lat_n1_vld", 32'(rsp_vld), 32'd0);
        @(negedge forever_cpuclk);
        check_eq("lat_n2_vld", 32'(rsp_vld), 32'd1);
        check_eq("lat_n2_data", rsp_rdata, 32'hA1B2FFD4);
        wait_drain("merge");

        // Zero byte-enable write leaves data untouched
        do_req(1'b1, 11'h010, 32'h12345678, 4'hF, w);
        do_req(1'b1, 11'h010, 32'hDEADBEEF, 4'h0, w);
        do_req(1'b0, 11'h010, 32'd0, 4'h0, w);
        wait_drain("be0");

        // Three reads with the consumer stalled
        for (int i = 0; i < 8; i++) do_req(1'b1, 11'(32 + i), $urandom, 4'hF, w);
        rsp_rdy = 1'b0;
        do_req(1'b0, 11'h020, 32'd0, 4'h0, w);
        do_req(1'b0, 11'h021, 32'd0, 4'h0, w);
        fork
            do_req(1'b0, 11'h022, 32'd0, 4'h0, w);
            begin
                @(negedge forever_cpuclk);
                check_eq("stall_rdy_drop", 32'(req_rdy), 32'd0);
                repeat (2) @(negedge forever_cpuclk);
                check_eq("stall_vld", 32'(rsp_vld), 32'd1);
                check_eq("stall_head", rsp_rdata, ref_mem[11'h020]);
                check_eq("stall_rdy_low", 32'(req_rdy), 32'd0);
                @(posedge forever_cpuclk);
                #1;
                rsp_rdy = 1'b1;
            end
        join
        wait_drain("stall");

        // Streaming reads with the consumer always ready
        wsum = 0;
        run  = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    do_req(1'b0, 11'(32 + i), 32'd0, 4'h0, w);
                    wsum += w;
                end
            end
            begin
                nwait = 0;
                @(negedge forever_cpuclk);
                while (!rsp_vld && nwait < 20) begin
                    nwait++;
                    @(negedge forever_cpuclk);
                end
                while (rsp_vld && run < 20) begin
                    run++;
                    @(negedge forever_cpuclk);
                end
            end
        join
        check_eq("stream_waits", 32'(wsum), 32'd0);
        check_eq("stream_run", 32'(run), 32'd8);
        @(posedge forever_cpuclk);
        #1;
        wait_drain("stream");

        // Random mix with a randomly stalling consumer
        rand_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    do_req(1'($urandom_range(0, 1)), 11'($urandom_range(0, 63)), $urandom,
                           4'($urandom_range(0, 15)), w);
                end
                rand_phase = 1'b0;
            end
            begin
                while (rand_phase) begin
                    @(posedge forever_cpuclk);
                    #1;
                    rsp_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_rdy = 1'b1;
        wait_drain("random");

        // Reset in RUN with a response buffered
        rsp_rdy = 1'b0;
        do_req(1'b0, 11'h005, 32'd0, 4'h0, w);
        repeat (2) @(negedge forever_cpuclk);
        check_eq("pend_vld", 32'(rsp_vld), 32'd1);
        #2;
        cpurst_b = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("rst_run");
        repeat (2) @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        clear_ref();

        // Reset again part-way through the clear sweep
        repeat (500) @(negedge forever_cpuclk);
        check_eq("mid_init_cen", 32'(sram_cen), 32'd0);
        check_eq("mid_init_done", 32'(init_done), 32'd0);
        #2;
        cpurst_b = 1'b0;
        #1;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        check_init_sweep("init2");

        // Earlier data wiped by the repeated clear
        rsp_rdy = 1'b1;
        do_req(1'b0, 11'h005, 32'd0, 4'h0, w);
        do_req(1'b0, 11'h010, 32'd0, 4'h0, w);
        do_req(1'b0, 11'h020, 32'd0, 4'h0, w);
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
